// File: rtl/symbol_demodulator_if.sv
// Received-sample stream into the symbol demodulator.
// Master drives samples, reference carrier and symbol framing.
interface symbol_demodulator_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] sample_in;
    logic [DATA_W-1:0] carrier_in;
    logic              sample_valid;
    logic              sym_start;

    modport master (
        output sample_in,
        output carrier_in,
        output sample_valid,
        output sym_start
    );

    modport slave (
        input sample_in,
        input carrier_in,
        input sample_valid,
        input sym_start
    );
endinterface

// File: rtl/symbol_demodulator.sv
// ASK/BPSK integrate-and-dump symbol demodulator.
// Define SYMBOL_DEMOD_SOFT_OUT_EN to expose the final accumulator as soft_out.
module symbol_demodulator #(
    parameter int DATA_W          = 12,
    parameter int SAMPLES_PER_SYM = 64,
    parameter int ACC_W           = DATA_W + 1 + $clog2(SAMPLES_PER_SYM)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    mode,
    input  logic [ACC_W-2:0]        threshold,
    symbol_demodulator_if.slave     rx,
    output logic                    bit_out,
    output logic                    bit_valid,
`ifdef SYMBOL_DEMOD_SOFT_OUT_EN
    output logic signed [ACC_W-1:0] soft_out,
`endif
    output logic                    resync
);

    localparam int CNT_W = $clog2(SAMPLES_PER_SYM + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLES_PER_SYM - 1);

    typedef enum logic [1:0] {
        IDLE, WAIT_SYNC, INTEGRATE, DECIDE
    } state_t;

    state_t state, state_nxt;

    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         count;
    logic                     mode_q;
    logic                     bit_q;
    logic                     start;
    logic                     term_mode;
    logic                     decision;
    logic signed [DATA_W:0]   s;
    logic signed [DATA_W:0]   term;
    logic signed [ACC_W-1:0]  term_ext;

    assign start = rx.sample_valid & rx.sym_start;

    // Flipping the MSB turns offset binary into two's complement.
    assign s = {{2{~rx.sample_in[DATA_W-1]}}, rx.sample_in[DATA_W-2:0]};

    // A symbol's first sample uses the live mode; the rest use the latched one.
    assign term_mode = (state == INTEGRATE && !start) ? mode_q : mode;

    always_comb begin
        term = s;
        if (term_mode) begin
            term = rx.carrier_in[DATA_W-1] ? s : -s;
        end else begin
            term = s[DATA_W] ? -s : s;
        end
    end

    assign term_ext = {{(ACC_W-DATA_W-1){term[DATA_W]}}, term};

    assign decision = mode_q ? !acc[ACC_W-1]
                             : (acc > $signed({1'b0, threshold}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:      state_nxt = WAIT_SYNC;
                WAIT_SYNC: if (start) state_nxt = INTEGRATE;
                INTEGRATE: begin
                    if (rx.sample_valid && !rx.sym_start && count == LAST)
                        state_nxt = DECIDE;
                end
                DECIDE:    state_nxt = WAIT_SYNC;
                default:   state_nxt = IDLE;
            endcase
        end
    end

`ifdef SYMBOL_DEMOD_SOFT_OUT_EN
    logic signed [ACC_W-1:0] soft_q;
`endif

    always_comb begin
        bit_valid = (state == DECIDE) && enable;
        bit_out   = bit_valid ? decision : bit_q;
`ifdef SYMBOL_DEMOD_SOFT_OUT_EN
        soft_out  = bit_valid ? acc : soft_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            count  <= '0;
            mode_q <= 1'b0;
            bit_q  <= 1'b0;
            resync <= 1'b0;
`ifdef SYMBOL_DEMOD_SOFT_OUT_EN
            soft_q <= '0;
`endif
        end else begin
            resync <= 1'b0;
            if (!enable) begin
                acc   <= '0;
                count <= '0;
            end else begin
                unique case (state)
                    WAIT_SYNC: begin
                        if (start) begin
                            acc    <= term_ext;
                            count  <= CNT_W'(1);
                            mode_q <= mode;
                        end
                    end
                    INTEGRATE: begin
                        if (start) begin
                            acc    <= term_ext;
                            count  <= CNT_W'(1);
                            mode_q <= mode;
                            resync <= 1'b1;
                        end else if (rx.sample_valid) begin
                            acc   <= acc + term_ext;
                            count <= count + CNT_W'(1);
                        end
                    end
                    DECIDE: begin
                        bit_q <= decision;
                        count <= '0;
`ifdef SYMBOL_DEMOD_SOFT_OUT_EN
                        soft_q <= acc;
`endif
                    end
                    default: begin
                        acc   <= '0;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule
